rom_vector_sequencer: RTL and testbench

//  Parametrised ROM test-vector sequencer. Drives operand pairs (out1, out2) into the
//  16x16 multiplier under test. Adds over the fixed 8-entry generator: width/depth

---
 rtl/rom_vector_sequencer.sv | 134 +++++++++++++
 tb/tb_rom_vector_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_vector_sequencer.sv
// rtl/rom_vector_sequencer.sv - ROM operand-pair sequencer with run modes and valid/ready output
module rom_vector_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter int OFFSET2 = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             stop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [AW-1:0]    addr,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  localparam logic [AW-1:0] OFF2      = AW'(OFFSET2 % DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    mode_q, mode_d;
  logic          valid_d, busy_d, done_d, load;
  logic          xfer, step_mode;

  // The 8-entry table repeats every 8 addresses; the word is trimmed or zero-extended to WIDTH.
  function automatic logic [WIDTH-1:0] rom_word(input logic [AW-1:0] a);
    logic [2:0]        i;
    logic [15:0]       w;
    logic [WIDTH+15:0] ext;
    i = 3'(a);
    case (i)
      3'd0:    w = 16'h000F;
      3'd1:    w = 16'h00FF;
      3'd2:    w = 16'h0FFF;
      3'd3:    w = 16'hFFFF;
      3'd4:    w = 16'h0045;
      3'd5:    w = 16'h01A4;
      3'd6:    w = 16'h35FB;
      default: w = 16'hCF27;
    endcase
    ext = {{WIDTH{1'b0}}, w};
    return ext[WIDTH-1:0];
  endfunction

  assign xfer      = out_valid & out_ready;
  assign step_mode = (mode_q == 2'b10);

  // Next-state and output decisions; a sequence ends by clearing valid and pulsing done together.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    valid_d = out_valid;
    busy_d  = busy;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = (mode == 2'b11) ? 2'b00 : mode;
          if (mode != 2'b10) ptr_d = '0;
        end
      end
      RUN: begin
        if (!out_valid) begin
          // First cycle after start: present the vector at ptr.
          load    = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          if (stop && !step_mode) state_d = LAST;
        end else if (xfer) begin
          ptr_d = ptr_q + AW'(1);
          if (step_mode || stop || (mode_q == 2'b00 && ptr_q == LAST_ADDR)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
          end
        end else if (stop && !step_mode) begin
          state_d = LAST;
        end
      end
      LAST: begin
        if (xfer) begin
          ptr_d   = ptr_q + AW'(1);
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; vector data only changes when a new vector is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      mode_q    <= 2'b00;
      out_valid <= 1'b0;
      out1      <= '0;
      out2      <= '0;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mode_q    <= mode_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      if (load) begin
        out1 <= rom_word(ptr_d);
        out2 <= rom_word(ptr_d + OFF2);
        addr <= ptr_d;
      end
    end
  end

endmodule

// File: tb/tb_rom_vector_sequencer.sv
// tb/tb_rom_vector_sequencer.sv - self-checking bench for rom_vector_sequencer
module tb_rom_vector_sequencer;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        v0, v3, b0, b3, d0, d3;
  logic [15:0] a1_0, a2_0, a1_3, a2_3;
  logic [2:0]  ad0, ad3;

  always #5 clk = ~clk;

  rom_vector_sequencer #(.WIDTH(16), .DEPTH(8), .OFFSET2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .stop(stop), .out_ready(out_ready),
    .out_valid(v0), .out1(a1_0), .out2(a2_0), .addr(ad0), .busy(b0), .done(d0));

  rom_vector_sequencer #(.WIDTH(16), .DEPTH(8), .OFFSET2(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .stop(stop), .out_ready(out_ready),
    .out_valid(v3), .out1(a1_3), .out2(a2_3), .addr(ad3), .busy(b3), .done(d3));

  logic [15:0] rom [8] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF,
                           16'h0045, 16'h01A4, 16'h35FB, 16'hCF27};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sequence-level view (idle / waiting for first vector / presenting / stopping).
  bit m_idle = 1'b1, m_first = 1'b0, m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_stopping = 1'b0;
  int m_ptr = 0, m_mode = 0;

  task automatic model_reset();
    m_idle = 1'b1; m_first = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
    m_done = 1'b0; m_stopping = 1'b0; m_ptr = 0; m_mode = 0;
  endtask

  task automatic model_step(input bit st, input logic [1:0] md, input bit sp, input bit rd);
    bit xfer, fin;
    xfer   = m_valid && rd;
    m_done = 1'b0;
    if (m_idle) begin
      if (st) begin
        m_idle  = 1'b0;
        m_first = 1'b1;
        m_mode  = (md == 2'b11) ? 0 : int'(md);
        if (m_mode != 2) m_ptr = 0;
      end
    end else if (m_first) begin
      m_first = 1'b0;
      m_valid = 1'b1;
      m_busy  = 1'b1;
      if (sp && m_mode != 2) m_stopping = 1'b1;
    end else if (xfer) begin
      fin   = (m_mode == 2) || m_stopping || sp || (m_mode == 0 && m_ptr == D - 1);
      m_ptr = (m_ptr + 1) % D;
      if (fin) begin
        m_idle = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_stopping = 1'b0;
      end
    end else if (sp && m_mode != 2) begin
      m_stopping = 1'b1;
    end
  endtask

  task automatic model_check();
    check("m_valid0", v0, m_valid);
    check("m_valid3", v3, m_valid);
    check("m_busy0", b0, m_busy);
    check("m_busy3", b3, m_busy);
    check("m_done0", d0, m_done);
    check("m_done3", d3, m_done);
    check("m_excl", d0 & v0, 1'b0);
    if (m_valid) begin
      check("m_addr0", ad0, m_ptr);
      check("m_addr3", ad3, m_ptr);
      check("m_out1_0", a1_0, rom[m_ptr]);
      check("m_out2_0", a2_0, rom[m_ptr]);
      check("m_out1_3", a1_3, rom[m_ptr]);
      check("m_out2_3", a2_3, rom[(m_ptr + 3) % D]);
    end
  endtask

  task automatic step(input bit st, input logic [1:0] md, input bit sp, input bit rd);
    start = st; mode = md; stop = sp; out_ready = rd;
    @(posedge clk);
    #1;
    model_step(st, md, sp, rd);
    model_check();
  endtask

  // Called #1 after an edge; reset must clear outputs without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_valid", {v0, v3}, 2'b00);
    check("rst_busy", {b0, b3}, 2'b00);
    check("rst_done", {d0, d3}, 2'b00);
    check("rst_addr", {ad0, ad3}, 6'd0);
    check("rst_out", {a1_0, a2_0, a1_3, a2_3}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_no_done", {d0, d3}, 2'b00);
    start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          st;
    logic [1:0]  md;
    bit          sp;
    bit          rd;
    bit          ev;
    logic [2:0]  ea;
    logic [15:0] e1;
    bit          eb;
    bit          ed;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h000F, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h00FF, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h00FF, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h00FF, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0FFF, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 3'd3, 16'hFFFF, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 3'd3, 16'hFFFF, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd3, 16'hFFFF, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0045, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h000F, 1'b1, 1'b0};

    #1;
    do_reset();

    // Table: back-pressure, stop into LAST, single-step from a retained pointer, start beats stop.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].st, tbl[i].md, tbl[i].sp, tbl[i].rd);
      check($sformatf("tbl%0d_valid", i), v0, tbl[i].ev);
      check($sformatf("tbl%0d_busy", i), b0, tbl[i].eb);
      check($sformatf("tbl%0d_done", i), d0, tbl[i].ed);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_addr", i), ad0, tbl[i].ea);
        check($sformatf("tbl%0d_out1", i), a1_0, tbl[i].e1);
      end
    end

    // Single pass continues from the table's last row: eight back-to-back vectors then done.
    for (int i = 0; i < D; i++) begin
      check("t2_addr", ad0, i);
      check("t2_out1", a1_0, rom[i]);
      check("t2_same", a2_0, a1_0);
      step(1'b0, 2'd0, 1'b0, 1'b1);
    end
    check("t2_done", {d0, b0, v0}, 3'b100);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("t2_done_pulse", d0, 1'b0);

    // Continuous with channel-2 offset, wrap, then stop under back-pressure.
    step(1'b1, 2'd1, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) step(1'b0, 2'd0, 1'b0, 1'b1);
    check("t4_addr7", ad3, 3'd7);
    check("t4_out1", a1_3, 16'hCF27);
    check("t4_out2", a2_3, 16'h0FFF);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("t4_wrap", ad3, 3'd0);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("t4_addr2", ad3, 3'd2);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    check("t4_held", {v3, ad3}, {1'b1, 3'd2});
    step(1'b0, 2'd0, 1'b0, 1'b0);
    check("t4_held2", {v3, ad3, b3}, {1'b1, 3'd2, 1'b1});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("t4_done", {d3, v3, b3}, 3'b100);

    // Single-step: three starts walk addresses 0,1,2.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 2'd2, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b0, 1'b0);
      check("t5_addr", ad0, r);
      check("t5_out1", a1_0, rom[r]);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      check("t5_done", {d0, v0}, 2'b10);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      check("t5_one_done", d0, 1'b0);
    end

    // Reset mid-run aborts without done; the next single pass restarts at 0.
    step(1'b1, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, 2'd0, 1'b0, 1'b1);
    check("t6_addr5", ad0, 3'd5);
    do_reset();
    step(1'b1, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("t6_restart", {v0, ad0, a1_0}, {1'b1, 3'd0, 16'h000F});

    // Random traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
